// File: rtl/regfile_if.sv
// Register-file port bundle: two read ports, two write ports and the clear/status handshake.
// The master drives addresses, data and enables. The slave is the register file.
interface regfile_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
);
    logic [ADDR_BITS-1:0] read_register1;
    logic [ADDR_BITS-1:0] read_register2;
    logic [WIDTH-1:0]     read_data1;
    logic [WIDTH-1:0]     read_data2;
    logic [ADDR_BITS-1:0] write_register_a;
    logic [ADDR_BITS-1:0] write_register_b;
    logic [WIDTH-1:0]     write_data_a;
    logic [WIDTH-1:0]     write_data_b;
    logic                 reg_write_a;
    logic                 reg_write_b;
    logic                 clear;
    logic                 busy;
    logic                 write_dropped;

    modport master (
        output read_register1, read_register2,
        output write_register_a, write_register_b, write_data_a, write_data_b,
        output reg_write_a, reg_write_b, clear,
        input  read_data1, read_data2, busy, write_dropped
    );

    modport slave (
        input  read_register1, read_register2,
        input  write_register_a, write_register_b, write_data_a, write_data_b,
        input  reg_write_a, reg_write_b, clear,
        output read_data1, read_data2, busy, write_dropped
    );
endinterface

// File: rtl/regfile_2w2r.sv
// Two-write, two-read register file with fixed B-over-A write priority, optional bypass,
// optional hardwired zero register and a one-register-per-cycle clear sequencer.
module regfile_2w2r #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t               state, state_next;
    logic [ADDR_BITS-1:0] clr_cnt, clr_cnt_next;
    logic [WIDTH-1:0]     regs [DEPTH];
    logic                 busy;
    logic                 wr_a, wr_b;
    logic                 write_dropped;
    logic [ADDR_BITS-1:0] raddr [2];
    logic [WIDTH-1:0]     rdata [2];

    assign busy = (state == CLEARING);

    // Writes to a hardwired register 0 are suppressed at the source.
    assign wr_a = bus.reg_write_a && !(ZERO_REG && bus.write_register_a == '0);
    assign wr_b = bus.reg_write_b && !(ZERO_REG && bus.write_register_b == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            IDLE: begin
                if (bus.clear) begin
                    state_next   = CLEARING;
                    clr_cnt_next = '0;
                end
            end
            CLEARING: begin
                clr_cnt_next = clr_cnt + ADDR_BITS'(1);
                if (clr_cnt == ADDR_BITS'(DEPTH - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the storage array is reset because a bulk zero on reset is part of its contract.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (busy) begin
            regs[clr_cnt] <= '0;
        end else begin
            // NOTE: non-blocking updates; on an address collision the later B assignment wins.
            if (wr_a) regs[bus.write_register_a] <= bus.write_data_a;
            if (wr_b) regs[bus.write_register_b] <= bus.write_data_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) write_dropped <= 1'b0;
        else     write_dropped <= busy && (bus.reg_write_a || bus.reg_write_b);
    end

    assign raddr[0] = bus.read_register1;
    assign raddr[1] = bus.read_register2;

    // Bypass priority mirrors the write priority: B first, then A, then stored contents.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            if (BYPASS && !busy) begin
                if (bus.reg_write_b && bus.write_register_b == raddr[p])
                    rdata[p] = bus.write_data_b;
                else if (bus.reg_write_a && bus.write_register_a == raddr[p])
                    rdata[p] = bus.write_data_a;
            end
            if (ZERO_REG && raddr[p] == '0) rdata[p] = '0;
        end
    end

    assign bus.read_data1    = rdata[0];
    assign bus.read_data2    = rdata[1];
    assign bus.busy          = busy;
    assign bus.write_dropped = write_dropped;
endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r: two builds (zero-reg+bypass, plain) driven in lockstep against
// an array-based reference model, with directed cases followed by random traffic.
module tb_regfile_2w2r;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ra1, ra2, wa, wb;
    logic [31:0] da, db;
    logic       we_a, we_b, clr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: contents per build, clear progress, dropped flag.
    logic [31:0] mem_z [DEPTH];
    logic [31:0] mem_n [DEPTH];
    logic        m_busy;
    int          m_pos;
    logic        m_drop;

    always #5 clk = ~clk;

    regfile_if #(.WIDTH(32), .ADDR_BITS(5)) bus_z ();
    regfile_if #(.WIDTH(32), .ADDR_BITS(5)) bus_n ();

    assign bus_z.read_register1 = ra1;   assign bus_n.read_register1 = ra1;
    assign bus_z.read_register2 = ra2;   assign bus_n.read_register2 = ra2;
    assign bus_z.write_register_a = wa;  assign bus_n.write_register_a = wa;
    assign bus_z.write_register_b = wb;  assign bus_n.write_register_b = wb;
    assign bus_z.write_data_a = da;      assign bus_n.write_data_a = da;
    assign bus_z.write_data_b = db;      assign bus_n.write_data_b = db;
    assign bus_z.reg_write_a = we_a;     assign bus_n.reg_write_a = we_a;
    assign bus_z.reg_write_b = we_b;     assign bus_n.reg_write_b = we_b;
    assign bus_z.clear = clr;            assign bus_n.clear = clr;

    regfile_2w2r #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z)
    );

    regfile_2w2r #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Expected combinational read for either build, from the current model and stimulus.
    function automatic logic [31:0] exp_read(input bit zero_build, input logic [4:0] addr);
        if (!zero_build) return mem_n[addr];
        if (addr == 5'd0) return 32'd0;
        if (!m_busy) begin
            if (we_b && wb == addr) return db;
            if (we_a && wa == addr) return da;
        end
        return mem_z[addr];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_z[i] = '0;
                mem_n[i] = '0;
            end
            m_busy = 1'b0;
            m_pos  = 0;
            m_drop = 1'b0;
        end else begin
            m_drop = m_busy && (we_a || we_b);
            if (m_busy) begin
                mem_z[m_pos] = '0;
                mem_n[m_pos] = '0;
                m_pos++;
                if (m_pos == DEPTH) begin
                    m_busy = 1'b0;
                    m_pos  = 0;
                end
            end else begin
                if (we_a) begin
                    mem_n[wa] = da;
                    if (wa != 5'd0) mem_z[wa] = da;
                end
                if (we_b) begin
                    mem_n[wb] = db;
                    if (wb != 5'd0) mem_z[wb] = db;
                end
                if (clr) begin
                    m_busy = 1'b1;
                    m_pos  = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0;
        we_b = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic check_reads();
        #1;
        check("rd1_z", bus_z.read_data1, exp_read(1'b1, ra1));
        check("rd2_z", bus_z.read_data2, exp_read(1'b1, ra2));
        check("rd1_n", bus_n.read_data1, exp_read(1'b0, ra1));
        check("rd2_n", bus_n.read_data2, exp_read(1'b0, ra2));
    endtask

    task automatic check_status();
        check("busy_z", {31'd0, bus_z.busy}, {31'd0, m_busy});
        check("busy_n", {31'd0, bus_n.busy}, {31'd0, m_busy});
        check("drop_z", {31'd0, bus_z.write_dropped}, {31'd0, m_drop});
        check("drop_n", {31'd0, bus_n.write_dropped}, {31'd0, m_drop});
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(DEPTH - 1 - i);
            #1;
            check({tag, "_z"}, bus_z.read_data1, 32'd0);
            check({tag, "_n"}, bus_n.read_data2, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cycles;

        rst = 1'b1;
        ra1 = '0; ra2 = '0; wa = '0; wb = '0; da = '0; db = '0;
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            mem_z[i] = 'x;
            mem_n[i] = 'x;
        end
        m_busy = 1'b0; m_pos = 0; m_drop = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check_status();
        check_all_zero("reset_rd");

        // Dual write to distinct addresses, then read and swap.
        wa = 5'd2; da = 32'd42; we_a = 1'b1;
        wb = 5'd7; db = 32'd15; we_b = 1'b1;
        tick();
        idle();
        ra1 = 5'd2; ra2 = 5'd7;
        check_reads();
        check("dual_rd1", bus_z.read_data1, 32'd42);
        check("dual_rd2", bus_z.read_data2, 32'd15);
        ra1 = 5'd7; ra2 = 5'd2;
        check_reads();

        // Same-address collision: B wins.
        wa = 5'd5; da = 32'd1; we_a = 1'b1;
        wb = 5'd5; db = 32'd2; we_b = 1'b1;
        tick();
        idle();
        ra1 = 5'd5;
        check_reads();
        check("collide_z", bus_z.read_data1, 32'd2);
        check("collide_n", bus_n.read_data1, 32'd2);

        // Register 0 written through both ports.
        wa = 5'd0; da = 32'd5; we_a = 1'b1;
        wb = 5'd0; db = 32'd5; we_b = 1'b1;
        tick();
        idle();
        ra1 = 5'd0; ra2 = 5'd0;
        check_reads();
        check("r0_zero", bus_z.read_data1, 32'd0);
        check("r0_plain", bus_n.read_data1, 32'd5);

        // Store 9 in reg3, then disabled writes must leave it alone.
        wa = 5'd3; da = 32'd9; we_a = 1'b1;
        tick();
        idle();
        wa = 5'd3; da = 32'd7; wb = 5'd3; db = 32'd7;
        tick();
        ra1 = 5'd3;
        check_reads();
        check("we_off", bus_z.read_data1, 32'd9);

        // Bypass visible before the edge only in the bypass build.
        wa = 5'd3; da = 32'd11; we_a = 1'b1;
        ra1 = 5'd3;
        check_reads();
        check("bypass_on", bus_z.read_data1, 32'd11);
        check("bypass_off", bus_n.read_data1, 32'd9);
        tick();
        idle();
        check_reads();
        check("bypass_post_z", bus_z.read_data1, 32'd11);
        check("bypass_post_n", bus_n.read_data1, 32'd11);

        // Clear sequence: fill 1..31 with their index, pulse clear, measure busy.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 1; i < DEPTH; i += 2) begin
            wa = 5'(i); da = 32'(i); we_a = 1'b1;
            wb = 5'(i + 1); db = 32'(i + 1); we_b = (i + 1 < DEPTH);
            tick();
        end
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        busy_cycles = 0;
        ra1 = 5'd31; ra2 = 5'd4;
        while (bus_z.busy && busy_cycles < 100) begin
            busy_cycles++;
            we_a = (busy_cycles == 5); wa = 5'd4; da = 32'd3;
            clr  = (busy_cycles == 10);
            check_reads();
            if (busy_cycles == 30) check("clr_r31_mid", bus_z.read_data1, 32'd31);
            tick();
            check_status();
            if (busy_cycles == 5) check("drop_pulse", {31'd0, bus_z.write_dropped}, 32'd1);
        end
        idle();
        check("busy_len", 32'(busy_cycles), 32'd32);
        check_reads();
        check("clr_r31_done", bus_z.read_data1, 32'd0);
        check("clr_r4_dropped", bus_z.read_data2, 32'd0);

        // Reset in the middle of a clear.
        wa = 5'd9; da = 32'd99; we_a = 1'b1;
        tick();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_status();
        check_all_zero("midclr_rst");
        wa = 5'd6; da = 32'd8; we_a = 1'b1;
        tick();
        idle();
        ra1 = 5'd6;
        check_reads();
        check("post_rst_wr", bus_z.read_data1, 32'd8);

        // Random traffic with occasional clears and resets.
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 149) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            we_a = $urandom_range(0, 1) == 1;
            we_b = $urandom_range(0, 1) == 1;
            wa   = 5'($urandom_range(0, DEPTH - 1));
            wb   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, DEPTH - 1));
            da   = $urandom;
            db   = $urandom;
            ra1  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, DEPTH - 1));
            ra2  = ($urandom_range(0, 2) == 0) ? wb : 5'($urandom_range(0, DEPTH - 1));
            check_reads();
            tick();
            check_status();
        end
        rst = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_2w2r.md
# regfile_2w2r

Parametrised multi-ported register file for the next CPU datapath: 2 combinational read ports, 2 write ports with fixed priority, optional write-to-read bypass, optional hardwired-zero register 0, synchronous bulk reset and a multi-cycle clear sequencer. It replaces the fixed 32x32, single-write-port register file and sits between decode (read addresses) and writeback (write addresses and data).

## Interface
- WIDTH, 32, data bits per register
- ADDR_BITS, 5, address bits; DEPTH = 2^ADDR_BITS registers
- ZERO_REG, 1, 1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary
- BYPASS, 1, 1: a read of an address being written this cycle returns the write data; 0: read returns stored value

- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock and this reset only
- ReadRegister1, ReadRegister2  in  ADDR_BITS  read addresses
- ReadData1, ReadData2  out  WIDTH  read data
- WriteRegisterA, WriteRegisterB  in  ADDR_BITS  write addresses
- WriteDataA, WriteDataB  in  WIDTH  write data
- RegWriteA, RegWriteB  in  1  write enables
- Clear  in  1  start clear sequence (sampled at rising edge)
- Busy  out  1  clear sequence in progress
- WriteDropped  out  1  one-cycle pulse: an enabled write was discarded

## Operation
- Reset=1 at an edge: all DEPTH registers <= 0, Busy <= 0, WriteDropped <= 0, clear counter <= 0. Reset overrides every other input, including mid-clear.
- Write: at an edge with Busy=0, RegWriteX=1 stores WriteDataX into WriteRegisterX. Both ports may write different addresses in the same edge.
- Same-address collision (both enables, equal addresses): port B wins; port A data discarded (not counted as dropped).
- ZERO_REG=1: writes to address 0 have no effect; ReadDataN = 0 whenever ReadRegisterN = 0, regardless of bypass.
- Read: ReadDataN = contents[ReadRegisterN], combinational.
- BYPASS=1 and Busy=0: if RegWriteB && WriteRegisterB == ReadRegisterN, ReadDataN = WriteDataB; else if RegWriteA && WriteRegisterA == ReadRegisterN, ReadDataN = WriteDataA; else stored value. Address-0 rule above takes precedence.
- Clear FSM, states IDLE and CLEARING:
  - IDLE: Clear=1 at an edge -> CLEARING, counter <= 0, Busy <= 1.
  - CLEARING: each edge writes 0 to register[counter], counter <= counter+1; at the edge clearing DEPTH-1 -> IDLE, Busy <= 0. Counter wraps naturally to 0.
  - Clear asserted while CLEARING: ignored (no restart).
- While Busy=1: all port writes are discarded, bypass is disabled, reads return current stored contents (not-yet-cleared registers still show old data). WriteDropped <= 1 at any edge where Busy=1 and (RegWriteA or RegWriteB); otherwise WriteDropped <= 0.

## Timing
- Write latency: value visible on ReadData immediately after the writing edge (same cycle when BYPASS=1).
- Read latency: 0 cycles (combinational from address).
- Clear: Clear sampled at edge N; Busy high from edge N through edge N+DEPTH; registers 0..DEPTH-1 cleared at edges N+1..N+DEPTH; Busy low after edge N+DEPTH; first accepted write at edge N+DEPTH+1. For DEPTH=32: Busy high exactly 32 cycles.
- WriteDropped: registered, high for the cycle after the offending edge.
- Reset values: Busy=0, WriteDropped=0, ReadData1/2=0 for every address.

## Test plan
- Defaults; reset, write A: reg2=42, write B: reg7=15 same edge; read port1=2, port2=7 -> 42, 15; swap addresses -> 15, 42.
- Collision: A and B both write reg5 (A=1, B=2) -> reg5 reads 2. Write reg0=5 via both ports -> reads 0 (ZERO_REG=1); with ZERO_REG=0 build -> reads 5.
- Bypass: reg3=9 stored; before edge drive write A reg3=11, read reg3 -> 11 pre-edge (BYPASS=1), 9 pre-edge (BYPASS=0); both -> 11 after edge.
- Write-enable off: RegWriteA=RegWriteB=0, WriteData=7 to reg3 holding 9 -> reads 9 after edge.
- Clear: fill regs 1..31 with index value, pulse Clear -> Busy high 32 cycles; reg31 still 31 at cycle 30, 0 after Busy falls; write reg4=3 during Busy -> not stored, WriteDropped high one cycle; Clear re-pulsed mid-sequence -> Busy duration unchanged.
- Reset mid-clear at cycle 10 of CLEARING -> next cycle Busy=0, all registers read 0, subsequent write reg6=8 reads 8.
